mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  Memory-access pipeline stage between the EX stage and the WB stage. It registers the EX payload,
//  takes the data-SRAM read data (valid exactly one cycle after EX issued the request), extracts and
//  extends load data, and forwards {pc, result, dest, gr_we, ex_SYS} to WB under a valid/allow_in handshake.
//  Read data is buffered internally so a WB back-pressure stall never loses it.
// PARAMETERS
//  TO_MEM_W  75  EX->MEM payload width {pc[31:0], alu_result[31:0], rd_1b, rd_2b, rd_4b, rd_signed, dest[4:0], gr_we, ex_SYS}
//  TO_WB_W   71  MEM->WB payload width {pc[31:0], final_result[31:0], dest[4:0], gr_we, ex_SYS}
// PORTS
//  clk              in   1         clock, all state updates on posedge
//  reset            in   1         synchronous, active-high
//  wb_ex            in   1         exception flush from WB; kills the instruction held in MEM
//  EX_to_MEM_valid  in   1         EX offers an instruction
//  MEM_allow_in     out  1         MEM can accept this cycle
//  to_MEM_data      in   TO_MEM_W  EX payload
//  WB_allow_in      in   1         WB can accept this cycle
//  MEM_to_WB_valid  out  1         MEM offers an instruction to WB
//  to_WB_data       out  TO_WB_W   payload to WB
//  data_sram_rdata  in   32        SRAM read data for the address EX presented in the previous cycle
//  MEM_forward      out  38        {fwd_dest[4:0], final_result[31:0], 1'b0} bypass to ID
// BEHAVIOUR
//  - Handshake: MEM_ready_go=1; MEM_allow_in = ~MEM_valid | WB_allow_in; MEM_to_WB_valid = MEM_valid.
//  - MEM_valid: 0 on reset or wb_ex (wb_ex beats a simultaneous accept); else if MEM_allow_in <= EX_to_MEM_valid.
//  - Payload reg: loaded when EX_to_MEM_valid & MEM_allow_in; reset to 0; held otherwise (not cleared by wb_ex).
//  - Read-data buffer: regs rdata_buf[31:0], buf_vld. In the first cycle an instruction is in MEM
//    (buf_vld=0), data_sram_rdata belongs to it. If MEM_valid & ~buf_vld & ~WB_allow_in: capture
//    rdata_buf<=data_sram_rdata, buf_vld<=1. buf_vld<=0 on reset, wb_ex, or any payload load
//    (incl. accept in the same cycle the current one leaves). raw = buf_vld ? rdata_buf : data_sram_rdata.
//  - Load extract, a=alu_result[1:0]: rd_1b -> byte a (a=0:[7:0],1:[15:8],2:[23:16],3:[31:24]);
//    rd_2b -> half a[1] (0:[15:0],1:[31:16]), a[0] ignored; rd_4b -> raw, a ignored.
//    rd_signed=1 sign-extends byte/half to 32 bits, else zero-extends.
//  - final_result = (rd_1b|rd_2b|rd_4b) ? load_data : alu_result. Flags assumed one-hot/zero from EX.
//  - to_WB_data = {pc, final_result, dest, gr_we, ex_SYS}; combinational from payload regs and raw data.
//  - fwd_dest = dest & {5{MEM_valid & gr_we}}; bit0 of MEM_forward = 0 (load data resolved here, no stall).
//  - Reset outputs: MEM_valid=0, MEM_to_WB_valid=0, MEM_allow_in=1, fwd_dest=0, to_WB_data pc/dest/flags=0.
//  - Latency: 1 cycle EX->WB when WB_allow_in=1; stall holds payload and buffered data unchanged.
//  - Reset or wb_ex mid-stall: instruction dropped, buffer invalidated, next cycle MEM_allow_in=1.
// TESTING
//  1. ld.w: EX offers alu_result=0x1000, next cycle rdata=0xDEADBEEF, WB_allow_in=1 ->
//     MEM_to_WB_valid=1, final_result=0xDEADBEEF, MEM_forward[37:33]=dest.
//  2. ld.b signed a=3 rdata=0x80112233 -> 0xFFFFFF80; ld.hu a=2 rdata=0x80112233 -> 0x00008011.
//  3. ld.w with WB_allow_in=0 for 3 cycles, rdata changes to 0x12345678 after cycle 1 ->
//     MEM_allow_in=0 while stalled, result stays original 0xDEADBEEF, delivered when WB_allow_in=1.
//  4. Back-to-back add (alu_result=0x5) then ld.w, WB always ready -> results 0x5 then rdata, one per cycle, buf_vld never set.
//  5. wb_ex while a load is stalled in MEM -> next cycle MEM_valid=0, MEM_to_WB_valid=0, fwd_dest=0, buf_vld=0.
//  6. reset asserted with EX_to_MEM_valid=1 -> MEM_valid=0, MEM_allow_in=1, to_WB_data=0 after the edge.

Source files
------------

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: payload register, SRAM read-data buffer, load extract, WB handoff
// Holds one instruction between EX and WB; read data is buffered so a WB stall never loses it.
module mem_stage #(
  parameter int TO_MEM_W = 75,
  parameter int TO_WB_W  = 71
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wb_ex,
  input  logic                EX_to_MEM_valid,
  output logic                MEM_allow_in,
  input  logic [TO_MEM_W-1:0] to_MEM_data,
  input  logic                WB_allow_in,
  output logic                MEM_to_WB_valid,
  output logic [TO_WB_W-1:0]  to_WB_data,
  input  logic [31:0]         data_sram_rdata,
  output logic [37:0]         MEM_forward
);

  logic                r_mem_valid;
  logic [TO_MEM_W-1:0] r_payload;
  logic [31:0]         r_rdata_buf;
  logic                r_buf_vld;

  logic        w_load;
  logic [31:0] w_pc;
  logic [31:0] w_alu_result;
  logic        w_rd_1b;
  logic        w_rd_2b;
  logic        w_rd_4b;
  logic        w_rd_signed;
  logic [4:0]  w_dest;
  logic        w_gr_we;
  logic        w_ex_sys;
  logic [31:0] w_raw;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_final_result;
  logic [4:0]  w_fwd_dest;

  assign w_pc         = r_payload[74:43];
  assign w_alu_result = r_payload[42:11];
  assign w_rd_1b      = r_payload[10];
  assign w_rd_2b      = r_payload[9];
  assign w_rd_4b      = r_payload[8];
  assign w_rd_signed  = r_payload[7];
  assign w_dest       = r_payload[6:2];
  assign w_gr_we      = r_payload[1];
  assign w_ex_sys     = r_payload[0];

  assign MEM_allow_in    = ~r_mem_valid | WB_allow_in;
  assign MEM_to_WB_valid = r_mem_valid;
  assign w_load          = EX_to_MEM_valid & MEM_allow_in;

  always_ff @(posedge clk) begin
    if (reset || wb_ex) begin
      r_mem_valid <= 1'b0;
    end else if (MEM_allow_in) begin
      r_mem_valid <= EX_to_MEM_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_payload <= '0;
    end else if (w_load) begin
      r_payload <= to_MEM_data;
    end
  end

  // SRAM data is only valid in the instruction's first MEM cycle; keep a copy if WB stalls.
  always_ff @(posedge clk) begin
    if (reset || wb_ex || w_load) begin
      r_buf_vld <= 1'b0;
    end else if (r_mem_valid && !r_buf_vld && !WB_allow_in) begin
      r_buf_vld   <= 1'b1;
      r_rdata_buf <= data_sram_rdata;
    end
  end

  assign w_raw = r_buf_vld ? r_rdata_buf : data_sram_rdata;

  always_comb begin
    w_byte      = 8'h00;
    w_half      = 16'h0000;
    w_load_data = 32'h0;
    case (w_alu_result[1:0])
      2'd0:    w_byte = w_raw[7:0];
      2'd1:    w_byte = w_raw[15:8];
      2'd2:    w_byte = w_raw[23:16];
      default: w_byte = w_raw[31:24];
    endcase
    w_half = w_alu_result[1] ? w_raw[31:16] : w_raw[15:0];
    if (w_rd_1b) begin
      w_load_data = {{24{w_rd_signed & w_byte[7]}}, w_byte};
    end else if (w_rd_2b) begin
      w_load_data = {{16{w_rd_signed & w_half[15]}}, w_half};
    end else begin
      w_load_data = w_raw;
    end
  end

  assign w_final_result = (w_rd_1b | w_rd_2b | w_rd_4b) ? w_load_data : w_alu_result;
  assign w_fwd_dest     = w_dest & {5{r_mem_valid & w_gr_we}};

  assign to_WB_data  = {w_pc, w_final_result, w_dest, w_gr_we, w_ex_sys};
  // Load data resolves in this stage, so the forward never requests a stall.
  assign MEM_forward = {w_fwd_dest, w_final_result, 1'b0};

endmodule
